// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - EX-stage issue/cancel/drain controller for the multi-cycle divider
module div_issue_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_div_valid,
    input  logic        ex_is_signed,
    input  logic [31:0] ex_op1,
    input  logic [31:0] ex_op2,
    input  logic        flush,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        div_start,
    output logic        div_cancel,
    output logic        div_is_signed,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    output logic        stall_req,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] drain_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            drain_cnt     <= '0;
            div_start     <= 1'b0;
            div_cancel    <= 1'b0;
            div_is_signed <= 1'b0;
            div_op1       <= '0;
            div_op2       <= '0;
            hilo_we       <= 1'b0;
            hi_wdata      <= '0;
            lo_wdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_div_valid && !flush) begin
                        div_op1       <= ex_op1;
                        div_op2       <= ex_op2;
                        div_is_signed <= ex_is_signed;
                        div_start     <= 1'b1;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    // Operands stay frozen here: the divider re-reads them for sign fixup.
                    if (flush) begin
                        div_start  <= 1'b0;
                        div_cancel <= 1'b1;
                        drain_cnt  <= '0;
                        state      <= DRAIN;
                    end else if (div_ready) begin
                        hi_wdata  <= div_result[63:32];
                        lo_wdata  <= div_result[31:0];
                        hilo_we   <= 1'b1;
                        div_start <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    hilo_we <= 1'b0;
                    state   <= IDLE;
                end
                DRAIN: begin
                    // Hold cancel long enough for the divider to reach its free state.
                    if (drain_cnt == CW'(DRAIN_CYCLES - 1)) begin
                        div_cancel <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall_req = !flush && (((state == IDLE) && ex_div_valid) ||
                                  (state == BUSY) ||
                                  ((state == DRAIN) && ex_div_valid));

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
EX-stage initiator for the multi-cycle divider; it is the requesting end of the start/cancel/ready/result handshake.
- On a DIV/DIVU in EX it latches the operands, drives the divider, and stalls the pipeline until the result returns.
- It then writes HI (remainder) and LO (quotient).
- On a pipeline flush it cancels the divide and drains the divider back to idle.

Parameters:
DRAIN_CYCLES, 2, cycles spent in DRAIN with div_cancel high and div_start low after a flush; must cover the divider's worst-case path back to its free state.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_div_valid  in  1  DIV/DIVU instruction present in EX
ex_is_signed  in  1  1 = DIV, 0 = DIVU
ex_op1  in  32  dividend (rs)
ex_op2  in  32  divisor (rt)
flush  in  1  pipeline flush/exception; kills the EX instruction this cycle
div_ready  in  1  divider result valid
div_result  in  64  divider result {remainder[63:32], quotient[31:0]}
div_start  out  1  divider start (registered)
div_cancel  out  1  divider cancel (registered)
div_is_signed  out  1  latched signedness (registered)
div_op1  out  32  latched dividend (registered)
div_op2  out  32  latched divisor (registered)
stall_req  out  1  stall request to pipeline control (combinational)
hilo_we  out  1  HI/LO write enable, one-cycle pulse (registered)
hi_wdata  out  32  remainder (registered)
lo_wdata  out  32  quotient (registered)

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; every registered output = 0; drain counter = 0. Reset mid-divide abandons the operation and produces no hilo_we.
- States: IDLE, BUSY, DONE, DRAIN.
- IDLE
  - If ex_div_valid & !flush: latch ex_op1, ex_op2, ex_is_signed into div_op1, div_op2, div_is_signed; div_start <= 1; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY
  - div_op1, div_op2 and div_is_signed are held constant: the divider reads them again at its sign-fixup step.
  - If flush: div_start <= 0, div_cancel <= 1, counter <= 0, go to DRAIN. Flush has priority over a same-cycle div_ready; that result is discarded.
  - Else if div_ready: hi_wdata <= div_result[63:32], lo_wdata <= div_result[31:0], hilo_we <= 1, div_start <= 0, go to DONE.
- DONE
  - Exactly one cycle. hilo_we = 1. div_start = 0, so the divider returns to free.
  - hilo_we <= 0; go to IDLE. A back-to-back DIV is accepted in the following IDLE cycle.
- DRAIN
  - div_cancel held at 1 and div_start at 0 for DRAIN_CYCLES cycles.
  - div_ready is ignored.
  - Then div_cancel <= 0 and go to IDLE. New requests are not accepted in DRAIN.
- stall_req = !flush & ((IDLE & ex_div_valid) | BUSY | (DRAIN & ex_div_valid)). It is 0 in DONE, so the DIV retires in the DONE cycle.
- Latency, with a DIV first seen in IDLE at cycle T:
  - Nonzero divisor: div_start high from T+1; div_ready high at T+36; hilo_we at T+37; stall_req high T..T+36.
  - Zero divisor: div_ready at T+4; hilo_we at T+5 with HI = LO = 0.
- No arithmetic is done here: the result is passed through bit-exact and signed fixup belongs to the divider. hilo_we never fires without a preceding div_ready in BUSY.

Test Plan:
- DIV -7 / 2 (0xFFFFFFF9, 0x00000002), no flush -> stall_req high T..T+36; hilo_we at T+37 only; LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 7 -> LO = 14, HI = 2; div_op1 and div_op2 stable from T+1 through T+36.
- DIVU 5 / 0 -> hilo_we at T+5, HI = LO = 0; div_start low in the DONE cycle.
- DIVU 100 / 7 with flush at T+10 -> div_cancel high T+11..T+12, div_start low from T+11, no hilo_we. A DIVU 9 / 4 issued at T+13 -> LO = 2, HI = 1.
- Two consecutive DIVs: 20 / 3 then 21 / 4 (DIVU) -> two separate hilo_we pulses with (LO, HI) = (6, 2) then (5, 1); the second div_start rises two cycles after the first DONE cycle.
- rst_n low at T+20 of a divide -> all outputs 0 immediately, state IDLE, no hilo_we after rst_n rises.
